// File: rtl/exclusive_max.sv
// ---------------------------------------------------------------------------
// exclusive_max
//   Race-logic exclusive-max cell. Each input carries one event per
//   computation window. The event time is the first 0->1 transition sampled
//   on aclk. q pulses after the later of the two arrivals, but only when a
//   and b arrive on different aclk edges. A tie, or a window in which only
//   one input arrives, leaves q low. A low q stands for "infinity".
//
// Parameters
//   OUT_PULSE_CYCLES : width of the q pulse in aclk cycles (>= 1)
//
// Ports
//   aclk : clock; all state updates on the rising edge
//   grst : asynchronous active-low global reset
//   rst  : synchronous active-high window clear (starts a new computation)
//   a    : event input A (level; an event is a sampled rising edge)
//   b    : event input B (level; an event is a sampled rising edge)
//   q    : registered result pulse
// ---------------------------------------------------------------------------
module exclusive_max #(
  parameter int unsigned OUT_PULSE_CYCLES = 1
) (
  input  logic aclk,
  input  logic grst,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic q
);

  localparam int unsigned CW = (OUT_PULSE_CYCLES > 1) ? $clog2(OUT_PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GOT_A,
    GOT_B,
    FIRE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          a_prev_q, a_prev_d;
  logic          b_prev_q, b_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  logic ev_a;
  logic ev_b;

  assign ev_a = a & ~a_prev_q;
  assign ev_b = b & ~b_prev_q;
  assign q    = q_q;

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state_q  <= IDLE;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
      cnt_q    <= '0;
      q_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_prev_q <= a_prev_d;
      b_prev_q <= b_prev_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = 1'b0;
    // The edge detectors track the inputs every cycle, including during a
    // window clear. An input that is already high at the clear therefore
    // does not count as an event afterwards.
    a_prev_d = a;
    b_prev_d = b;

    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_a && ev_b) begin
            state_d = DONE;            // tie: the result is infinity
          end else if (ev_a) begin
            state_d = GOT_A;
          end else if (ev_b) begin
            state_d = GOT_B;
          end
        end
        GOT_A: begin
          if (ev_b) begin
            state_d = FIRE;
            cnt_d   = '0;
          end
        end
        GOT_B: begin
          if (ev_a) begin
            state_d = FIRE;
            cnt_d   = '0;
          end
        end
        FIRE: begin
          // q is driven from here, so the pulse appears one edge after the
          // later event was sampled. cnt_q counts the high cycles already
          // scheduled.
          q_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          // Hold until the next window clear.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exclusive_max.sv
// ---------------------------------------------------------------------------
// tb_exclusive_max
//   Runs two instances of exclusive_max side by side, with pulse widths 1 and
//   3, on shared stimulus. A window-level model records the first event time
//   of each input since the last clear. q must be high exactly on the P edges
//   that follow the later arrival, and only when the two arrival times differ.
//   Directed windows add hand-computed literal expectations. Randomized
//   traffic then exercises the general case.
// ---------------------------------------------------------------------------
module tb_exclusive_max;

  logic aclk = 1'b0;
  logic grst = 1'b0;
  logic rst  = 1'b0;
  logic a    = 1'b0;
  logic b    = 1'b0;
  logic q1;
  logic q3;

  int tests  = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  exclusive_max #(.OUT_PULSE_CYCLES(1)) dut1 (
    .aclk(aclk), .grst(grst), .rst(rst), .a(a), .b(b), .q(q1)
  );

  exclusive_max #(.OUT_PULSE_CYCLES(3)) dut3 (
    .aclk(aclk), .grst(grst), .rst(rst), .a(a), .b(b), .q(q3)
  );

  // ---------------- window-level reference model ----------------
  int k      = 0;    // edge counter
  int t_a    = -1;   // edge of first A arrival in the current window
  int t_b    = -1;   // edge of first B arrival in the current window
  bit prev_a = 1'b0;
  bit prev_b = 1'b0;
  bit exp1;
  bit exp3;

  function automatic bit model_q(input int ta, input int tb, input int edge_k, input int p);
    int later;
    if (ta < 0 || tb < 0 || ta == tb) return 1'b0;
    later = (ta > tb) ? ta : tb;
    return (edge_k > later) && (edge_k <= later + p);
  endfunction

  always @(posedge aclk) begin
    k = k + 1;
    if (!grst) begin
      t_a = -1; t_b = -1; prev_a = 1'b0; prev_b = 1'b0;
    end else if (rst) begin
      t_a = -1; t_b = -1; prev_a = a; prev_b = b;
    end else begin
      if (a && !prev_a && t_a < 0) t_a = k;
      if (b && !prev_b && t_b < 0) t_b = k;
      prev_a = a;
      prev_b = b;
    end
    exp1 = model_q(t_a, t_b, k, 1);
    exp3 = model_q(t_a, t_b, k, 3);
    #1;
    tests = tests + 1;
    if (q1 !== exp1) begin
      errors = errors + 1;
      $display("FAIL model_q_p1 edge=%0d got=%b exp=%b", k, q1, exp1);
    end
    tests = tests + 1;
    if (q3 !== exp3) begin
      errors = errors + 1;
      $display("FAIL model_q_p3 edge=%0d got=%b exp=%b", k, q3, exp3);
    end
  end

  // ---------------- directed windows with literal checks ----------------
  bit qr1 [0:63];
  bit qr3 [0:63];

  task automatic chk(input string name, input int got, input int exp);
    tests = tests + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, got);
    end
  endtask

  // Clear the window (the clear is sampled on edge 0), then drive len edges.
  // ea/eb: edge on which a/b first rise (0 = never). rst_at: edge that
  // samples a second clear (0 = none). a_hold: a is already high at the
  // clear. dip: a and b are forced low on edges 15..17 so that they re-rise
  // on edge 18.
  task automatic run_window(input int ea, input int eb, input int rst_at,
                            input bit a_hold, input bit dip, input int len);
    @(negedge aclk);
    a = a_hold; b = 1'b0; rst = 1'b1;
    for (int n = 1; n <= len; n++) begin
      @(negedge aclk);
      if (n > 1) begin
        qr1[n-1] = q1;
        qr3[n-1] = q3;
      end
      a   = a_hold || (ea > 0 && n >= ea);
      b   = (eb > 0 && n >= eb);
      if (dip && n >= 15 && n <= 17) begin
        a = 1'b0;
        b = 1'b0;
      end
      rst = (n == rst_at);
    end
    @(negedge aclk);
    qr1[len] = q1;
    qr3[len] = q3;
    rst = 1'b0; a = 1'b0; b = 1'b0;
  endtask

  function automatic int ones1(input int len);
    int s = 0;
    for (int n = 1; n <= len; n++) s += int'(qr1[n]);
    return s;
  endfunction

  function automatic int ones3(input int len);
    int s = 0;
    for (int n = 1; n <= len; n++) s += int'(qr3[n]);
    return s;
  endfunction

  initial begin
    // Global reset
    repeat (3) @(negedge aclk);
    chk("reset_q1", int'(q1), 0);
    chk("reset_q3", int'(q3), 0);
    grst = 1'b1;

    // No events for 40 cycles
    run_window(0, 0, 0, 1'b0, 1'b0, 40);
    chk("idle_q1_pulses", ones1(40), 0);
    chk("idle_q3_pulses", ones3(40), 0);

    // a first, b later
    run_window(10, 20, 0, 1'b0, 1'b0, 30);
    chk("ab_q1_e20", int'(qr1[20]), 0);
    chk("ab_q1_e21", int'(qr1[21]), 1);
    chk("ab_q1_e22", int'(qr1[22]), 0);
    chk("ab_q1_pulses", ones1(30), 1);
    chk("ab_q3_e23", int'(qr3[23]), 1);
    chk("ab_q3_e24", int'(qr3[24]), 0);
    chk("ab_q3_pulses", ones3(30), 3);

    // b first, a later
    run_window(20, 10, 0, 1'b0, 1'b0, 30);
    chk("ba_q1_e21", int'(qr1[21]), 1);
    chk("ba_q1_pulses", ones1(30), 1);
    chk("ba_q3_e21", int'(qr3[21]), 1);

    // Tie, with later re-rising edges on both inputs
    run_window(10, 10, 0, 1'b0, 1'b1, 30);
    chk("tie_q1_pulses", ones1(30), 0);
    chk("tie_q3_pulses", ones3(30), 0);

    // a already high at the clear, b rises later: only one event
    run_window(0, 5, 0, 1'b1, 1'b0, 20);
    chk("held_q1_pulses", ones1(20), 0);
    chk("held_q3_pulses", ones3(20), 0);

    // A window clear during the pulse aborts it
    run_window(10, 12, 15, 1'b0, 1'b0, 20);
    chk("abort_q3_e12", int'(qr3[12]), 0);
    chk("abort_q3_e13", int'(qr3[13]), 1);
    chk("abort_q3_e14", int'(qr3[14]), 1);
    chk("abort_q3_e15", int'(qr3[15]), 0);
    chk("abort_q1_e13", int'(qr1[13]), 1);
    chk("abort_q1_e14", int'(qr1[14]), 0);

    // Randomized traffic, checked by the model on every edge
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      if ($urandom_range(0, 499) == 0) begin
        grst = 1'b0;
        @(negedge aclk);
        grst = 1'b1;
      end
    end

    @(negedge aclk);
    @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
